key_entry_strobe: RTL and testbench

- Producer side of the keypad-entry interface: turns a raw DE10 pushbutton plus 4 slide switches into clean, single-cycle key strobes (en_key) with a stable 4-bit key value.
- Sits between board I/O and the password checker/counter block. One strobe per debounced press; lockout suppresses strobes while the buzzer/alarm is active.
- Tracks digit position within a 4-digit entry frame.

---
 rtl/key_entry_pkg.sv | 16 +
 rtl/key_entry_strobe_sync_ff.sv | 28 ++
 rtl/key_entry_strobe.sv | 125 ++++++++++++
 tb/tb_key_entry_strobe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_pkg.sv
// Shared types and default constants for the keypad-entry strobe generator.
package key_entry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_KEY_W           = 4;
    localparam int DEF_DIGITS          = 4;

endpackage

// File: rtl/key_entry_strobe_sync_ff.sv
// Multi-stage synchronizer for asynchronous board inputs, with a configurable
// reset value so idle levels (button released, switches low) come out of reset.
module sync_ff #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    // NOTE: non-blocking assignments here so every stage samples its
    // predecessor's old value; blocking would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= {DEPTH{RST_VAL}};
        end else begin
            pipe <= {pipe[DEPTH-2:0], d};
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/key_entry_strobe.sv
// Debounces the keypad pushbutton and emits one single-cycle strobe per accepted
// press, with the switch value captured as the key and a digit position tracker.
module key_entry_strobe
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int KEY_W           = DEF_KEY_W,
    parameter int DIGITS          = DEF_DIGITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      btn_n,
    input  logic [KEY_W-1:0]          sw,
    input  logic                      lockout,
    input  logic                      entry_clr,
    output logic                      en_key,
    output logic [KEY_W-1:0]          key,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_last,
    output logic                      busy
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int                 DIG_W    = $clog2(DIGITS);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIG_W-1:0]   LAST_DIG = DIG_W'(DIGITS - 1);

    logic             btn_s;
    logic [KEY_W-1:0] sw_s;
    logic             pressed;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             press_done;
    logic             strobe;

    sync_ff #(.WIDTH(1), .DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_s)
    );

    sync_ff #(.WIDTH(KEY_W), .DEPTH(SYNC_STAGES), .RST_VAL('0)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    assign pressed = ~btn_s;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        press_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (pressed) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt == LAST_CNT) begin
                    state_d    = HELD;
                    press_done = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lockout only gates the strobe; the FSM still walks the full press/release.
    assign strobe = press_done && !lockout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            en_key     <= 1'b0;
            key        <= '0;
            frame_last <= 1'b0;
            digit_idx  <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            en_key     <= strobe;
            frame_last <= strobe && (digit_idx == LAST_DIG);
            if (strobe) begin
                key <= sw_s;
            end
            if (entry_clr) begin
                digit_idx <= '0;
            end else if (strobe) begin
                digit_idx <= (digit_idx == LAST_DIG) ? '0 : digit_idx + DIG_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_entry_strobe.sv
// Self-checking bench for key_entry_strobe: press table, bounce/reset sequences,
// and randomized stimulus compared every cycle against a run-length model.
module tb_key_entry_strobe;

    localparam int DC     = 4;
    localparam int SS     = 2;
    localparam int KW     = 4;
    localparam int DIGITS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_n;
    logic [KW-1:0] sw;
    logic          lockout;
    logic          entry_clr;
    logic          en_key;
    logic [KW-1:0] key;
    logic [1:0]    digit_idx;
    logic          frame_last;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    key_entry_strobe #(
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SS),
        .KEY_W           (KW),
        .DIGITS          (DIGITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .sw         (sw),
        .lockout    (lockout),
        .entry_clr  (entry_clr),
        .en_key     (en_key),
        .key        (key),
        .digit_idx  (digit_idx),
        .frame_last (frame_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a press is accepted after DC+1 consecutive low samples of
    // the synchronized button while armed; it re-arms after DC+1 consecutive highs.
    bit [SS-1:0]   m_sb;
    logic [KW-1:0] m_sw [SS];
    bit            m_armed;
    int            m_low, m_high, m_idx;
    logic          m_en, m_fl;
    logic [KW-1:0] m_key;
    bit            m_valid = 1'b0;
    bit            m_fire;

    always @(posedge clk) begin
        if (rst) begin
            m_sb    = '1;
            for (int k = 0; k < SS; k++) m_sw[k] = '0;
            m_armed = 1'b1;
            m_low   = 0;
            m_high  = 0;
            m_en    = 1'b0;
            m_fl    = 1'b0;
            m_key   = '0;
            m_idx   = 0;
            m_valid = 1'b1;
        end else begin
            m_en   = 1'b0;
            m_fl   = 1'b0;
            m_fire = 1'b0;
            if (m_armed) begin
                if (!m_sb[SS-1]) begin
                    m_low++;
                    if (m_low == DC + 1) begin
                        m_fire  = 1'b1;
                        m_armed = 1'b0;
                        m_high  = 0;
                    end
                end else begin
                    m_low = 0;
                end
            end else begin
                if (m_sb[SS-1]) begin
                    m_high++;
                    if (m_high == DC + 1) begin
                        m_armed = 1'b1;
                        m_low   = 0;
                    end
                end else begin
                    m_high = 0;
                end
            end
            if (m_fire && !lockout) begin
                m_en  = 1'b1;
                m_key = m_sw[SS-1];
                m_fl  = (m_idx == DIGITS - 1);
                m_idx = (m_idx + 1) % DIGITS;
            end
            if (entry_clr) m_idx = 0;
            m_sb = {m_sb[SS-2:0], btn_n};
            for (int k = SS - 1; k > 0; k--) m_sw[k] = m_sw[k-1];
            m_sw[0] = sw;
        end
    end

    always @(negedge clk) begin
        if (m_valid && !rst) begin
            check("model en_key",     {31'd0, en_key},     {31'd0, m_en});
            check("model key",        {28'd0, key},        {28'd0, m_key});
            check("model digit_idx",  {30'd0, digit_idx},  m_idx);
            check("model frame_last", {31'd0, frame_last}, {31'd0, m_fl});
            check("model busy",       {31'd0, busy},       {31'd0, (!m_armed || m_low > 0)});
        end
    end

    typedef struct {
        logic [KW-1:0] sw;
        bit            lock;
        bit            clr;
        int            exp_pulses;
        logic [KW-1:0] exp_key;
        bit            exp_fl;
        int            exp_idx;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, pulse_edge, hold;
        logic [KW-1:0] got_key;
        bit fl_seen;

        tbl[0] = '{4'h5, 1'b0, 1'b0, 1, 4'h5, 1'b0, 1};
        tbl[1] = '{4'h3, 1'b0, 1'b0, 1, 4'h3, 1'b0, 2};
        tbl[2] = '{4'h7, 1'b1, 1'b0, 0, 4'h3, 1'b0, 2};
        tbl[3] = '{4'h7, 1'b0, 1'b1, 1, 4'h7, 1'b0, 0};
        tbl[4] = '{4'h3, 1'b0, 1'b0, 1, 4'h3, 1'b0, 1};
        tbl[5] = '{4'h5, 1'b0, 1'b0, 1, 4'h5, 1'b0, 2};
        tbl[6] = '{4'h7, 1'b0, 1'b0, 1, 4'h7, 1'b0, 3};
        tbl[7] = '{4'h9, 1'b0, 1'b0, 1, 4'h9, 1'b1, 0};

        rst = 1'b1; btn_n = 1'b1; sw = '0; lockout = 1'b0; entry_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset en_key",     {31'd0, en_key},     0);
        check("reset key",        {28'd0, key},        0);
        check("reset digit_idx",  {30'd0, digit_idx},  0);
        check("reset frame_last", {31'd0, frame_last}, 0);
        check("reset busy",       {31'd0, busy},       0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full press/release per table row; pulse must land on edge SS+DC+1
        // counting the first edge that samples btn_n low as edge 1.
        for (int r = 0; r < 8; r++) begin
            sw = tbl[r].sw; lockout = tbl[r].lock; btn_n = 1'b0;
            pulses = 0; pulse_edge = 0; fl_seen = 1'b0; got_key = '0;
            for (int i = 1; i <= 24; i++) begin
                @(posedge clk); @(negedge clk);
                if (en_key) begin pulses++; pulse_edge = i; got_key = key; end
                if (frame_last) fl_seen = 1'b1;
                if (i == 6 && tbl[r].clr) entry_clr = 1'b1;
                if (i == 7) entry_clr = 1'b0;
                if (i == 9) lockout = 1'b0;
                if (i == 12) btn_n = 1'b1;
            end
            check($sformatf("row%0d pulses", r), pulses, tbl[r].exp_pulses);
            check($sformatf("row%0d pulse_edge", r), pulse_edge,
                  (tbl[r].exp_pulses != 0) ? SS + DC + 1 : 0);
            if (tbl[r].exp_pulses != 0)
                check($sformatf("row%0d key at strobe", r), {28'd0, got_key}, {28'd0, tbl[r].exp_key});
            check($sformatf("row%0d key held", r), {28'd0, key}, {28'd0, tbl[r].exp_key});
            check($sformatf("row%0d frame_last", r), {31'd0, fl_seen}, {31'd0, tbl[r].exp_fl});
            check($sformatf("row%0d digit_idx", r), {30'd0, digit_idx}, tbl[r].exp_idx);
            check($sformatf("row%0d busy idle", r), {31'd0, busy}, 0);
        end

        // Bounce: low 2 / high 1 never reaches the debounce threshold.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn_n = (i >= 10) ? 1'b1 : ((i % 3) == 2);
            @(posedge clk); @(negedge clk);
            if (en_key) pulses++;
        end
        check("bounce pulses", pulses, 0);
        check("bounce busy", {31'd0, busy}, 0);
        check("bounce digit_idx", {30'd0, digit_idx}, 0);

        // Randomized stimulus, checked cycle by cycle by the model.
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                btn_n = 1'($urandom_range(0, 1));
                hold  = $urandom_range(1, 9);
            end
            hold--;
            sw        = KW'($urandom);
            if ($urandom_range(0, 7) == 0) lockout = ~lockout;
            entry_clr = ($urandom_range(0, 15) == 0);
            @(posedge clk); @(negedge clk);
        end
        btn_n = 1'b1; lockout = 1'b0; entry_clr = 1'b0;
        repeat (15) @(negedge clk);

        // Reset while in DEB_PRESS with the counter at 2, button kept low.
        sw = 4'hA; btn_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin @(posedge clk); @(negedge clk); end
        check("pre-reset busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midreset en_key",     {31'd0, en_key},     0);
        check("midreset key",        {28'd0, key},        0);
        check("midreset digit_idx",  {30'd0, digit_idx},  0);
        check("midreset frame_last", {31'd0, frame_last}, 0);
        check("midreset busy",       {31'd0, busy},       0);
        rst = 1'b0;
        pulses = 0; pulse_edge = 0; got_key = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (en_key) begin pulses++; pulse_edge = i; got_key = key; end
        end
        check("post-reset pulses", pulses, 1);
        check("post-reset pulse_edge", pulse_edge, SS + DC + 1);
        check("post-reset key", {28'd0, got_key}, 32'hA);
        check("post-reset digit_idx", {30'd0, digit_idx}, 1);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        check("final busy", {31'd0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
